// File: rtl/demux_deser_pkg.sv
// Shared encodings for the demux deserializer: output-port state and channel ids.
package demux_deser_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_id_e;

endpackage

// File: rtl/demux_deser_chan.sv
// One deserializer channel: shift register, bit counter and a one-entry valid/ready output port.
// Bit order is selected by DEMUX_DESER_MSB_FIRST_EN (undefined: first bit lands in bit 0).
module demux_deser_chan
    import demux_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    output logic             ovf_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Handshake: a word transfers on any edge where out_valid_o && out_ready_i.
    // out_valid_o is the output state itself (ST_FULL), so the port state is always visible.
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q;
    logic             ovf_q;
    out_state_e       state_q;
    logic             complete;
    logic             drain;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (bit_valid_i) begin
`ifdef DEMUX_DESER_MSB_FIRST_EN
            shift_d = {shift_q[WIDTH-2:0], bit_i};
`else
            shift_d = {bit_i, shift_q[WIDTH-1:1]};
`endif
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign complete = bit_valid_i && (cnt_q == LAST);
    assign drain    = (state_q == ST_FULL) && out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            state_q <= ST_EMPTY;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ovf_q   <= 1'b0;
            case (state_q)
                ST_EMPTY: begin
                    if (complete) begin
                        data_q  <= shift_d;
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // The held word wins over a new one unless it leaves this same edge.
                    if (complete && drain) begin
                        data_q <= shift_d;
                    end else if (complete) begin
                        ovf_q <= 1'b1;
                    end else if (drain) begin
                        state_q <= ST_EMPTY;
                    end
                end
            endcase
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = (state_q == ST_FULL);
    assign ovf_o       = ovf_q;

endmodule

// File: rtl/demux_chan_deser.sv
// Top level: decodes demux enable/select into per-channel bit strobes and packs each channel into words.
// Optional DEMUX_DESER_MSB_FIRST_EN selects MSB-first packing inside the channels.
module demux_chan_deser
    import demux_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e,
    input  logic             s,
    input  logic             i0,
    input  logic             i1,
    output logic [WIDTH-1:0] out_data0,
    output logic             out_valid0,
    input  logic             out_ready0,
    output logic [WIDTH-1:0] out_data1,
    output logic             out_valid1,
    input  logic             out_ready1,
    output logic             ovf0,
    output logic             ovf1
);

    logic bit_valid0;
    logic bit_valid1;

    assign bit_valid0 = e && (s == CH0);
    assign bit_valid1 = e && (s == CH1);

    demux_deser_chan #(.WIDTH(WIDTH)) u_chan0 (
        .clk         (clk),
        .rst         (rst),
        .bit_valid_i (bit_valid0),
        .bit_i       (i0),
        .out_ready_i (out_ready0),
        .out_data_o  (out_data0),
        .out_valid_o (out_valid0),
        .ovf_o       (ovf0)
    );

    demux_deser_chan #(.WIDTH(WIDTH)) u_chan1 (
        .clk         (clk),
        .rst         (rst),
        .bit_valid_i (bit_valid1),
        .bit_i       (i1),
        .out_ready_i (out_ready1),
        .out_data_o  (out_data1),
        .out_valid_o (out_valid1),
        .ovf_o       (ovf1)
    );

endmodule
